// File: rtl/sid_voice_mixer.sv
`default_nettype none
// ============================================================================
// Module      : sid_voice_mixer
// Description : Splits three SID voices plus the external input into a
//               saturated filter input and a bypass sum, one channel per clock.
// Revision    : 1.0 - initial release
// ============================================================================

module sid_voice_mixer #(
    parameter int MID = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [11:0] voice1,
    input  logic [11:0] voice2,
    input  logic [11:0] voice3,
    input  logic [11:0] ext_in,
    input  logic [3:0]  filt,
    input  logic        voice3_off,
    output logic [11:0] filter_in,
    output logic [13:0] bypass,
    output logic        valid,
    output logic        busy
);

    localparam logic [12:0]        c_mid      = 13'(MID);
    localparam logic signed [13:0] c_clamp_hi = 14'sd2047;
    localparam logic signed [13:0] c_clamp_lo = -14'sd2048;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_start;
    logic [1:0]         r_step;
    logic [3:0][11:0]   r_ch;
    logic [3:0]         r_filt;
    logic               r_v3off;
    logic signed [13:0] r_filt_acc;
    logic signed [13:0] r_byp_acc;

    logic [11:0]        w_ch;
    logic [12:0]        w_d;
    logic               w_to_filt;
    logic               w_muted;
    logic signed [13:0] w_operand;
    logic signed [13:0] w_sum;
    logic [11:0]        w_clamped;

    // Single shared adder: the routing bit of the current step selects
    // which accumulator is fed back as the second operand.
    always_comb begin
        w_ch      = r_ch[r_step];
        w_d       = {1'b0, w_ch} - c_mid;
        w_to_filt = r_filt[r_step];
        w_muted   = (r_step == 2'd2) && !w_to_filt && r_v3off;
        w_operand = w_to_filt ? r_filt_acc : r_byp_acc;
        w_sum     = w_operand + $signed({w_d[12], w_d});
        if (r_filt_acc > c_clamp_hi) begin
            w_clamped = 12'h7FF;
        end else if (r_filt_acc < c_clamp_lo) begin
            w_clamped = 12'h800;
        end else begin
            w_clamped = r_filt_acc[11:0];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sample_en) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                if (r_step == 2'd3) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step     <= 2'd0;
            r_ch       <= '0;
            r_filt     <= 4'd0;
            r_v3off    <= 1'b0;
            r_filt_acc <= 14'sd0;
            r_byp_acc  <= 14'sd0;
            filter_in  <= 12'd0;
            bypass     <= 14'd0;
            valid      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ch       <= {ext_in, voice3, voice2, voice1};
                        r_filt     <= filt;
                        r_v3off    <= voice3_off;
                        r_step     <= 2'd0;
                        r_filt_acc <= 14'sd0;
                        r_byp_acc  <= 14'sd0;
                        busy       <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (!w_muted) begin
                        if (w_to_filt) begin
                            r_filt_acc <= w_sum;
                        end else begin
                            r_byp_acc <= w_sum;
                        end
                    end
                    r_step <= r_step + 2'd1;
                end
                S_OUT: begin
                    filter_in <= w_clamped;
                    bypass    <= r_byp_acc;
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                end
                default: busy <= 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/sid_voice_mixer.md
Name: sid_voice_mixer

Overview:
Stage directly upstream of the SID state-variable filter. Once per audio sample it takes the three voice outputs and the external input, and uses the FILT routing bits to split them into two sums: a saturated 12-bit signed filter input and a 14-bit signed bypass sum for the output mixer. One shared adder is time-multiplexed by a small sequencer over the four channels.

Parameters:
MID, 2048, DC midpoint subtracted from each unsigned 12-bit channel.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sample_en  input  1  single-cycle strobe that starts one mixing pass
voice1  input  12  voice 1 output, unsigned, midpoint MID
voice2  input  12  voice 2 output, unsigned, midpoint MID
voice3  input  12  voice 3 output, unsigned, midpoint MID
ext_in  input  12  external audio input, unsigned, midpoint MID
filt  input  4  routing: bit0 voice1, bit1 voice2, bit2 voice3, bit3 ext; 1 = to filter
voice3_off  input  1  3OFF; mutes voice 3 in bypass only
filter_in  output  12  signed two's-complement filter input, saturated
bypass  output  14  signed two's-complement sum of unfiltered channels
valid  output  1  one-cycle pulse; filter_in and bypass updated this cycle
busy  output  1  high while a pass is in progress

Behaviour:
- Reset is synchronous and active-high. In reset: filter_in=0, bypass=0, valid=0, busy=0, both accumulators=0, state=IDLE.
- Capture: on the edge where sample_en=1 and state=IDLE, register voice1..3, ext_in, filt and voice3_off. Go to ACC with step=0 and clear both accumulators. Set busy=1 from the next cycle.
- Inputs that change after capture have no effect on the current pass.
- sample_en while busy=1 is ignored. It is neither queued nor allowed to restart the pass.
- ACC, one channel per edge, steps 0..3 = voice1, voice2, voice3, ext:
  - d = channel - MID, a 13-bit signed value in -2048..2047.
  - If the channel's filt bit is 1, filt_acc += d; otherwise byp_acc += d.
  - Exception: voice3 with filt[2]=0 and voice3_off=1 adds to neither accumulator.
  - voice3 with filt[2]=1 goes to the filter regardless of voice3_off.
- Accumulators are 14-bit signed, range -8192..8188. They cannot overflow.
- OUT, the edge after step 3:
  - filter_in = filt_acc clamped to [-2048, 2047].
  - bypass = byp_acc, no clamping.
  - valid=1 for exactly this one cycle, then busy=0 and state=IDLE.
- Latency: capture at edge N; steps at edges N+1..N+4; outputs and valid at edge N+5. A new sample_en is accepted at edge N+6 or later (valid and sample_en may coincide at N+5 → ignored).
- filter_in and bypass hold their value between passes.
- Reset asserted mid-pass aborts the pass: no valid pulse, outputs return to 0.
- States: IDLE → ACC(step 0..3) → OUT → IDLE. Unused encodings recover to IDLE.

Test Plan:
- All inputs 2048, filt=0000, sample_en pulse → valid exactly 5 cycles after capture edge, filter_in=0, bypass=0, busy high for 5 cycles.
- voice1=voice2=4095, voice3=ext=2048, filt=0011 → filter_in=2047 (sum 4094 saturates), bypass=0.
- All inputs 0, filt=1111 → filter_in=-2048 (12'h800). Then filt=0000 → bypass=-8192 (14'h2000), filter_in=0.
- voice3=3072, others 2048:
  - filt=0000, voice3_off=1 → bypass=0.
  - voice3_off=0 → bypass=1024.
  - filt=0100, voice3_off=1 → filter_in=1024, bypass=0.
- sample_en again at capture+2, and inputs changed at capture+1 → only one valid pulse, with results from the originally captured inputs.
- Reset asserted at capture+3 → no valid pulse, filter_in=0, bypass=0, busy=0. The next sample_en completes normally.
